// File: rtl/seg_angle_scan.sv
// Multiplexed 4-digit 7-segment display of one axis's BCD angle plus an axis label.
// Axis auto-rotates or is stepped by a debounced key; all changes land on frame boundaries.
module seg_angle_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CNT    = 1000000,
  parameter int ROT_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] angle_g,
  input  logic [3:0] angle_s,
  input  logic [3:0] angle_b,
  input  logic [3:0] angley_g,
  input  logic [3:0] angley_s,
  input  logic [3:0] angley_b,
  input  logic [3:0] anglez_g,
  input  logic [3:0] anglez_s,
  input  logic [3:0] anglez_b,
  input  logic       key_n,
  input  logic       auto_en,
  output logic [7:0] seg,
  output logic [3:0] sel,
  output logic [1:0] axis
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEB_CNT);
  localparam int RW = $clog2(ROT_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(DEB_CNT - 1);
  localparam logic [RW-1:0] ROT_LAST = RW'(ROT_FRAMES - 1);

  typedef enum logic [1:0] {AX_X = 2'd0, AX_Y = 2'd1, AX_Z = 2'd2} axis_t;

  axis_t         axis_q, axis_nxt;
  logic          key_s1, key_s2, key_stable, press, pend;
  logic [BW-1:0] deb_cnt;
  logic [DW-1:0] div_cnt;
  logic [1:0]    dig_idx;
  logic [RW-1:0] rot_cnt;
  logic          div_term, frame_tick, advance;
  logic [3:0]    snap_b, snap_s, snap_g, nxt_b, nxt_s, nxt_g;

  function automatic logic [7:0] bcd_seg(input logic [3:0] d);
    case (d)
      4'd0: bcd_seg = 8'hC0;
      4'd1: bcd_seg = 8'hF9;
      4'd2: bcd_seg = 8'hA4;
      4'd3: bcd_seg = 8'hB0;
      4'd4: bcd_seg = 8'h99;
      4'd5: bcd_seg = 8'h92;
      4'd6: bcd_seg = 8'h82;
      4'd7: bcd_seg = 8'hF8;
      4'd8: bcd_seg = 8'h80;
      4'd9: bcd_seg = 8'h90;
      default: bcd_seg = 8'hBF;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt    <= '0;
      key_stable <= 1'b1;
    end else if (key_s2 == key_stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      key_stable <= key_s2;
      deb_cnt    <= '0;
    end else begin
      deb_cnt <= deb_cnt + BW'(1);
    end
  end

  // Press fires in the same cycle the stable level falls.
  assign press      = key_stable && !key_s2 && (deb_cnt == DEB_LAST);
  assign div_term   = (div_cnt == DIV_LAST);
  assign frame_tick = div_term && (dig_idx == 2'd3);
  assign advance    = frame_tick && (pend || press || (auto_en && rot_cnt == ROT_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (div_term) begin
      div_cnt <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pend <= 1'b0;
    else if (frame_tick) pend <= 1'b0;
    else if (press)      pend <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rot_cnt <= '0;
    else if (!auto_en || press) rot_cnt <= '0;
    else if (frame_tick)     rot_cnt <= advance ? '0 : rot_cnt + RW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) axis_q <= AX_X;
    else     axis_q <= axis_nxt;
  end

  always_comb begin
    axis_nxt = axis_q;
    if (advance) begin
      case (axis_q)
        AX_X:    axis_nxt = AX_Y;
        AX_Y:    axis_nxt = AX_Z;
        default: axis_nxt = AX_X;
      endcase
    end
  end

  always_comb begin
    nxt_b = angle_b;
    nxt_s = angle_s;
    nxt_g = angle_g;
    case (axis_nxt)
      AX_Y: begin nxt_b = angley_b; nxt_s = angley_s; nxt_g = angley_g; end
      AX_Z: begin nxt_b = anglez_b; nxt_s = anglez_s; nxt_g = anglez_g; end
      default: ;
    endcase
  end

  // Snapshot only at frame boundaries so one frame never mixes old and new digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_b <= 4'd0;
      snap_s <= 4'd0;
      snap_g <= 4'd0;
    end else if (frame_tick) begin
      snap_b <= nxt_b;
      snap_s <= nxt_s;
      snap_g <= nxt_g;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 8'hFF;
      sel <= 4'hF;
    end else begin
      case (dig_idx)
        2'd0: begin
          sel <= 4'b1110;
          seg <= bcd_seg(snap_g);
        end
        2'd1: begin
          sel <= 4'b1101;
          seg <= (snap_b == 4'd0 && snap_s == 4'd0) ? 8'hFF : bcd_seg(snap_s);
        end
        2'd2: begin
          sel <= 4'b1011;
          seg <= (snap_b == 4'd0) ? 8'hFF : bcd_seg(snap_b);
        end
        default: begin
          sel <= 4'b0111;
          case (axis_q)
            AX_X:    seg <= 8'h89;
            AX_Y:    seg <= 8'h91;
            AX_Z:    seg <= 8'h24;
            default: seg <= 8'hFF;
          endcase
        end
      endcase
    end
  end

  assign axis = axis_q;

endmodule

// File: tb/tb_seg_angle_scan.sv
// Directed bench for seg_angle_scan with short scan/debounce/rotate parameters.
module tb_seg_angle_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] angle_g, angle_s, angle_b;
  logic [3:0] angley_g, angley_s, angley_b;
  logic [3:0] anglez_g, anglez_s, anglez_b;
  logic       key_n, auto_en;
  logic [7:0] seg;
  logic [3:0] sel;
  logic [1:0] axis;

  int checks = 0;
  int failures = 0;

  seg_angle_scan #(.SCAN_DIV(4), .DEB_CNT(8), .ROT_FRAMES(3)) dut (
    .clk(clk), .rst(rst),
    .angle_g(angle_g), .angle_s(angle_s), .angle_b(angle_b),
    .angley_g(angley_g), .angley_s(angley_s), .angley_b(angley_b),
    .anglez_g(anglez_g), .anglez_s(anglez_s), .anglez_b(anglez_b),
    .key_n(key_n), .auto_en(auto_en),
    .seg(seg), .sel(sel), .axis(axis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Align to the first cycle of a units slot (label -> units transition).
  task automatic sync_units(input string tag);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = sel;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && sel == 4'b1110) found = 1'b1;
      prev = sel;
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL %s_sync observed=no_frame_start expected=frame_start", tag);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] eu, input logic [7:0] et,
                             input logic [7:0] eh, input logic [7:0] el, input logic [1:0] eax);
    sync_units(tag);
    chk({tag, "_axis"}, {6'd0, axis}, {6'd0, eax});
    chk({tag, "_sel0"}, {4'd0, sel}, 8'h0E);
    chk({tag, "_units"}, seg, eu);
    step(4);
    chk({tag, "_sel1"}, {4'd0, sel}, 8'h0D);
    chk({tag, "_tens"}, seg, et);
    step(4);
    chk({tag, "_sel2"}, {4'd0, sel}, 8'h0B);
    chk({tag, "_hund"}, seg, eh);
    step(4);
    chk({tag, "_sel3"}, {4'd0, sel}, 8'h07);
    chk({tag, "_label"}, seg, el);
  endtask

  task automatic press_key(input int n);
    key_n = 1'b0;
    step(n);
    key_n = 1'b1;
  endtask

  logic [7:0] ex_u[3], ex_t[3], ex_h[3], ex_l[3];
  logic [1:0] auto_seq[9];

  initial begin
    rst = 1'b1; key_n = 1'b1; auto_en = 1'b0;
    angle_b = 4'd1;  angle_s = 4'd2;  angle_g = 4'd3;
    angley_b = 4'd0; angley_s = 4'd4; angley_g = 4'd5;
    anglez_b = 4'd3; anglez_s = 4'd6; anglez_g = 4'd0;
    step(2);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_sel", {4'd0, sel}, 8'h0F);
    chk("rst_axis", {6'd0, axis}, 8'h00);
    rst = 1'b0;

    check_frame("x123", 8'hB0, 8'hA4, 8'hF9, 8'h89, 2'd0);
    angle_b = 4'd0; angle_s = 4'd0; angle_g = 4'd7;
    check_frame("x007", 8'hF8, 8'hFF, 8'hFF, 8'h89, 2'd0);
    angle_b = 4'd0; angle_s = 4'd5; angle_g = 4'd0;
    check_frame("x050", 8'hC0, 8'h92, 8'hFF, 8'h89, 2'd0);
    angle_s = 4'hC;
    check_frame("x0c0", 8'hC0, 8'hBF, 8'hFF, 8'h89, 2'd0);
    angle_b = 4'hA; angle_s = 4'd0; angle_g = 4'd9;
    check_frame("xa09", 8'h90, 8'hC0, 8'hBF, 8'h89, 2'd0);

    // A 5-cycle glitch is shorter than the debounce window.
    press_key(5);
    check_frame("glitch_a", 8'h90, 8'hC0, 8'hBF, 8'h89, 2'd0);
    check_frame("glitch_b", 8'h90, 8'hC0, 8'hBF, 8'h89, 2'd0);

    press_key(20);
    check_frame("press_y", 8'h92, 8'h99, 8'hFF, 8'h91, 2'd1);
    check_frame("press_y_hold", 8'h92, 8'h99, 8'hFF, 8'h91, 2'd1);

    ex_u[0] = 8'h90; ex_t[0] = 8'hC0; ex_h[0] = 8'hBF; ex_l[0] = 8'h89;
    ex_u[1] = 8'h92; ex_t[1] = 8'h99; ex_h[1] = 8'hFF; ex_l[1] = 8'h91;
    ex_u[2] = 8'hC0; ex_t[2] = 8'h82; ex_h[2] = 8'hB0; ex_l[2] = 8'h24;
    auto_seq = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1};
    auto_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check_frame($sformatf("auto%0d", i), ex_u[auto_seq[i]], ex_t[auto_seq[i]],
                  ex_h[auto_seq[i]], ex_l[auto_seq[i]], auto_seq[i]);
    end
    auto_en = 1'b0;

    // Y inputs change mid-frame; the frame in flight must keep the old digits.
    sync_units("mid");
    chk("mid_units_old", seg, 8'h92);
    step(4);
    angley_b = 4'd1; angley_s = 4'd0; angley_g = 4'd8;
    chk("mid_tens_old", seg, 8'h99);
    step(4);
    chk("mid_hund_old", seg, 8'hFF);
    step(4);
    chk("mid_label", seg, 8'h91);
    check_frame("mid_new", 8'h80, 8'hC0, 8'hF9, 8'h91, 2'd1);

    press_key(20);
    check_frame("press_z", 8'hC0, 8'h82, 8'hB0, 8'h24, 2'd2);

    sync_units("pre_rst");
    step(6);
    rst = 1'b1;
    #1;
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_sel", {4'd0, sel}, 8'h0F);
    chk("midrst_axis", {6'd0, axis}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check_frame("post_rst", 8'h90, 8'hC0, 8'hBF, 8'h89, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
